// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard sequencer: cause codes, stage control bundle,
// and the source/destination register match helper.
package hazard_controller_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_LOAD   = 2'd1,
      HZ_MDU    = 2'd2,
      HZ_FROZEN = 2'd3
   } hz_cause_e;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   function automatic logic src_hit(input logic uses,
                                    input logic [REG_IDX_W-1:0] src,
                                    input logic [REG_IDX_W-1:0] dest);
      return uses && (src == dest);
   endfunction

endpackage

// File: rtl/hazard_controller_mdu_busy_timer.sv
// Mult/div occupancy timer: loads MDU_LATENCY-1 on an accepted start, otherwise
// counts down to zero every cycle (also while the pipeline is held).
module mdu_busy_timer #(
   parameter int MDU_LATENCY = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic hold,
   output logic busy
);

   localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

   logic [CW-1:0] count_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (start && !hold) begin
         count_reg <= CW'(MDU_LATENCY - 1);
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CW'(1);
      end
   end

   assign busy = (count_reg != '0);

   // The issue logic never starts a new mult/div while one is still in flight.
   assert property (@(posedge clock) disable iff (reset) !(start && !hold && busy))
      else $error("mdu_busy_timer: start while busy");

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, redirect, MDU, memory wait).
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MDU_LATENCY = 8,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 id_mdu_use,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_dest,
   input  logic                 ex_redirect,
   input  logic                 ex_mdu_start,
   input  logic                 mem_wait,
   output logic                 pc_en,
   output logic                 ifid_en,
   output logic                 idex_en,
   output logic                 exmem_en,
   output logic                 memwb_en,
   output logic                 ifid_flush,
   output logic                 idex_flush,
   output logic                 mdu_busy,
   output logic [1:0]           hz_state,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
);

   hz_cause_e   cause;
   hz_cause_e   hz_reg;
   logic        redirect_act;
   logic        load_use;
   logic        pc_ctl;
   stage_ctrl_t ifid, idex, exmem, memwb;

   mdu_busy_timer #(.MDU_LATENCY(MDU_LATENCY)) u_mdu_timer (
      .clock (clock),
      .reset (reset),
      .start (ex_mdu_start),
      .hold  (mem_wait),
      .busy  (mdu_busy)
   );

   // Register 0 is hard-wired, so a load targeting it never feeds a consumer.
   assign load_use = ex_mem_read && (ex_dest != '0) &&
                     (src_hit(id_uses_rs, id_rs, ex_dest) || src_hit(id_uses_rt, id_rt, ex_dest));

   always_comb begin
      cause        = HZ_RUN;
      redirect_act = 1'b0;
      if (mem_wait)                    cause        = HZ_FROZEN;
      else if (ex_redirect)            redirect_act = 1'b1;
      else if (id_mdu_use && mdu_busy) cause        = HZ_MDU;
      else if (load_use)               cause        = HZ_LOAD;
   end

   always_comb begin
      pc_ctl      = 1'b1;
      ifid.en     = 1'b1;
      ifid.flush  = 1'b0;
      idex.en     = 1'b1;
      idex.flush  = 1'b0;
      exmem.en    = 1'b1;
      exmem.flush = 1'b0;
      memwb.en    = 1'b1;
      memwb.flush = 1'b0;
      if (reset) begin
         pc_ctl     = 1'b0;
         ifid.en    = 1'b0;
         idex.en    = 1'b0;
         exmem.en   = 1'b0;
         memwb.en   = 1'b0;
         ifid.flush = 1'b1;
         idex.flush = 1'b1;
      end else if (cause == HZ_FROZEN) begin
         pc_ctl   = 1'b0;
         ifid.en  = 1'b0;
         idex.en  = 1'b0;
         exmem.en = 1'b0;
         memwb.en = 1'b0;
      end else if (redirect_act) begin
         ifid.flush = 1'b1;
         idex.flush = 1'b1;
      end else if (cause == HZ_MDU || cause == HZ_LOAD) begin
         // Hold PC and IF/ID, inject a bubble into EX, let older instructions drain.
         pc_ctl     = 1'b0;
         ifid.en    = 1'b0;
         idex.flush = 1'b1;
      end
   end

   assign pc_en      = pc_ctl;
   assign ifid_en    = ifid.en;
   assign idex_en    = idex.en;
   assign exmem_en   = exmem.en;
   assign memwb_en   = memwb.en;
   assign ifid_flush = ifid.flush;
   assign idex_flush = idex.flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) hz_reg <= HZ_RUN;
      else       hz_reg <= cause;
   end

   assign hz_state = hz_reg;

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [CNT_WIDTH-1:0] stall_reg;
   logic [CNT_WIDTH-1:0] flush_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_reg <= '0;
         flush_reg <= '0;
      end else begin
         if (!pc_ctl)      stall_reg <= stall_reg + CNT_WIDTH'(1);
         if (redirect_act) flush_reg <= flush_reg + CNT_WIDTH'(1);
      end
   end

   assign stall_cycles = stall_reg;
   assign flush_events = flush_reg;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller with a scoreboard queue for registered outputs.
module tb_hazard_controller;

   localparam int MDU_LAT = 8;
   localparam int CW      = 32;

   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
   localparam logic [6:0] C_RUN   = 7'b11111_00;
   localparam logic [6:0] C_STALL = 7'b00111_01;
   localparam logic [6:0] C_REDIR = 7'b11111_11;
   localparam logic [6:0] C_FROZ  = 7'b00000_00;
   localparam logic [6:0] C_RST   = 7'b00000_11;

   typedef struct {
      string      name;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       mdu_use;
      logic       mrd;
      logic [4:0] dest;
      logic       redir;
      logic       start;
      logic       mwait;
      logic [6:0] ctl;
      logic [1:0] hz;
   } vec_t;

   typedef struct {
      logic [1:0]    hz;
      logic          busy;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic [4:0]    id_rs, id_rt, ex_dest;
   logic          id_uses_rs, id_uses_rt, id_mdu_use, ex_mem_read, ex_redirect, ex_mdu_start, mem_wait;
   logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mdu_busy;
   logic [1:0]    hz_state;
   logic [CW-1:0] stall_cycles, flush_events;

   int checks   = 0;
   int failures = 0;
   int m_cnt    = 0;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_flush = '0;
   exp_t sb[$];
   vec_t tbl[14];

   hazard_controller #(.MDU_LATENCY(MDU_LAT), .CNT_WIDTH(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_mdu_use   (id_mdu_use),
      .ex_mem_read  (ex_mem_read),
      .ex_dest      (ex_dest),
      .ex_redirect  (ex_redirect),
      .ex_mdu_start (ex_mdu_start),
      .mem_wait     (mem_wait),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .memwb_en     (memwb_en),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .mdu_busy     (mdu_busy),
      .hz_state     (hz_state),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic mdu_use, input logic mrd,
                               input logic [4:0] dest, input logic redir, input logic start,
                               input logic mwait, input logic [6:0] ctl, input logic [1:0] hz);
      vec_t v;
      v.name = name; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mdu_use = mdu_use;
      v.mrd = mrd; v.dest = dest; v.redir = redir; v.start = start; v.mwait = mwait;
      v.ctl = ctl; v.hz = hz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [6:0] ctl_now();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
   endfunction

   task automatic step(input vec_t v);
      exp_t e;
      @(negedge clock);
      id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt; id_mdu_use = v.mdu_use;
      ex_mem_read = v.mrd; ex_dest = v.dest; ex_redirect = v.redir; ex_mdu_start = v.start;
      mem_wait = v.mwait;
      #1;
      chk({v.name, ".ctl"}, 64'(ctl_now()), 64'(v.ctl));
      chk({v.name, ".busy_pre"}, 64'(mdu_busy), 64'(m_cnt != 0));
      if (v.start && !v.mwait) m_cnt = MDU_LAT - 1;
      else if (m_cnt != 0)     m_cnt = m_cnt - 1;
`ifdef HAZARD_PERF_COUNTERS_EN
      if (!v.ctl[6])           m_stall = m_stall + 1'b1;
      if (v.redir && !v.mwait) m_flush = m_flush + 1'b1;
`endif
      e.hz = v.hz; e.busy = (m_cnt != 0); e.stall = m_stall; e.flush = m_flush;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk({v.name, ".hz_state"}, 64'(hz_state), 64'(e.hz));
      chk({v.name, ".busy_post"}, 64'(mdu_busy), 64'(e.busy));
      chk({v.name, ".stall_cycles"}, 64'(stall_cycles), 64'(e.stall));
      chk({v.name, ".flush_events"}, 64'(flush_events), 64'(e.flush));
      $display("txn %-14s ctl=%b hz=%0d busy=%0b stalls=%0d flushes=%0d",
               v.name, ctl_now(), hz_state, mdu_busy, stall_cycles, flush_events);
   endtask

   task automatic check_reset_state(input string name);
      chk({name, ".ctl"}, 64'(ctl_now()), 64'(C_RST));
      chk({name, ".busy"}, 64'(mdu_busy), 64'd0);
      chk({name, ".hz_state"}, 64'(hz_state), 64'd0);
      chk({name, ".stall_cycles"}, 64'(stall_cycles), 64'd0);
      chk({name, ".flush_events"}, 64'(flush_events), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //            name             rs rt urs urt mdu mrd dest red st  mw  ctl      hz
      tbl[0]  = mk("idle",           0, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_RUN,   2'd0);
      tbl[1]  = mk("loaduse_rs",     8, 3, 1,  1,  0,  1,  8,   0,  0,  0,  C_STALL, 2'd1);
      tbl[2]  = mk("after_load",     8, 3, 1,  1,  0,  0,  8,   0,  0,  0,  C_RUN,   2'd0);
      tbl[3]  = mk("loaduse_rt",     4, 9, 1,  1,  0,  1,  9,   0,  0,  0,  C_STALL, 2'd1);
      tbl[4]  = mk("rt_unused",      4, 9, 1,  0,  0,  1,  9,   0,  0,  0,  C_RUN,   2'd0);
      tbl[5]  = mk("rs_unused",      9, 4, 0,  1,  0,  1,  9,   0,  0,  0,  C_RUN,   2'd0);
      tbl[6]  = mk("load_r0",        0, 0, 1,  1,  0,  1,  0,   0,  0,  0,  C_RUN,   2'd0);
      tbl[7]  = mk("redir_loaduse",  8, 3, 1,  1,  0,  1,  8,   1,  0,  0,  C_REDIR, 2'd0);
      tbl[8]  = mk("frozen_redir1",  0, 0, 0,  0,  0,  0,  0,   1,  0,  1,  C_FROZ,  2'd3);
      tbl[9]  = mk("frozen_redir2",  0, 0, 0,  0,  0,  0,  0,   1,  0,  1,  C_FROZ,  2'd3);
      tbl[10] = mk("frozen_redir3",  0, 0, 0,  0,  0,  0,  0,   1,  0,  1,  C_FROZ,  2'd3);
      tbl[11] = mk("redir_release",  0, 0, 0,  0,  0,  0,  0,   1,  0,  0,  C_REDIR, 2'd0);
      tbl[12] = mk("frozen_loaduse", 8, 3, 1,  1,  0,  1,  8,   0,  0,  1,  C_FROZ,  2'd3);
      tbl[13] = mk("mdu_use_idle",   0, 0, 0,  0,  1,  0,  0,   0,  0,  0,  C_RUN,   2'd0);

      reset = 1'b1;
      id_rs = '0; id_rt = '0; ex_dest = '0;
      id_uses_rs = 0; id_uses_rt = 0; id_mdu_use = 0; ex_mem_read = 0;
      ex_redirect = 0; ex_mdu_start = 0; mem_wait = 0;
      #12;
      check_reset_state("reset");
      @(negedge clock);
      reset = 1'b0;

      foreach (tbl[i]) step(tbl[i]);

      // mult issued while mfhi sits in ID: busy only shows up next cycle
      step(mk("mdu_start_use", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, C_RUN, 2'd0));
      for (int i = 0; i < MDU_LAT - 1; i++)
         step(mk("mfhi_stall", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_STALL, 2'd2));
      step(mk("mfhi_go", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_RUN, 2'd0));

      // redirect and memory wait take priority over an MDU stall; timer keeps counting while frozen
      step(mk("mdu_start2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN, 2'd0));
      step(mk("mdu_redirect", 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, C_REDIR, 2'd0));
      step(mk("mdu_frozen", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_FROZ, 2'd3));
      for (int i = 0; i < MDU_LAT - 3; i++)
         step(mk("mdu_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0));
      step(mk("start_frozen", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FROZ, 2'd3));
      step(mk("use_after_frz", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_RUN, 2'd0));

      // async reset in the middle of an MDU countdown
      step(mk("mdu_start3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN, 2'd0));
      step(mk("count_6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0));
      step(mk("count_5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0));
      step(mk("loaduse_cnt4", 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, C_STALL, 2'd1));
      chk("pre_reset.busy", 64'(mdu_busy), 64'd1);
      @(negedge clock);
      v = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0);
      id_rs = v.rs; id_uses_rs = v.urs; ex_mem_read = v.mrd; ex_dest = v.dest;
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("async_reset");
      $display("txn %-14s ctl=%b hz=%0d busy=%0b", "async_reset", ctl_now(), hz_state, mdu_busy);
      m_cnt = 0; m_stall = '0; m_flush = '0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      step(mk("post_reset", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_RUN, 2'd0));
      step(mk("post_loaduse", 7, 0, 1, 0, 0, 1, 7, 0, 0, 0, C_STALL, 2'd1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
